// File: rtl/whistle_qualifier.sv
// -----------------------------------------------------------------------------
// whistle_qualifier
//
// Qualifies per-frame whistle detections coming out of an FFT tone detector.
// A whistle is declared once CONFIRM consecutive hit frames land within
// BIN_TOL bins of each other. The indication is then stretched for
// HOLD_CYCLES clocks after the tone is lost, so short dropouts do not
// split one whistle into several.
//
// Ports
//   clk            in   sole clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   frame_valid    in   one-cycle strobe per completed FFT frame
//   frame_hit      in   detector fired for this frame (used only with frame_valid)
//   frame_bin      in   peak bin of this frame (used only with frame_valid)
//   clear_count    in   synchronous clear of event_count
//   whistle_active out  qualified and stretched whistle indication
//   whistle_start  out  one-cycle pulse when a new whistle qualifies
//   whistle_end    out  one-cycle pulse when whistle_active deasserts
//   whistle_bin    out  bin of the current/last qualified whistle
//   event_count    out  saturating count of qualified whistles
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module whistle_qualifier #(
  parameter int BIN_W       = 8,
  parameter int CONFIRM     = 3,
  parameter int BIN_TOL     = 2,
  parameter int HOLD_CYCLES = 12_500_000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_valid,
  input  logic             frame_hit,
  input  logic [BIN_W-1:0] frame_bin,
  input  logic             clear_count,
  output logic             whistle_active,
  output logic             whistle_start,
  output logic             whistle_end,
  output logic [BIN_W-1:0] whistle_bin,
  output logic [CNT_W-1:0] event_count
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = '0;
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [BIN_W:0]    TOL       = (BIN_W + 1)'(BIN_TOL);
  localparam logic [3:0]        CONFIRM_N = 4'(CONFIRM);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
  localparam logic [BIN_W-1:0]  BIN_ZERO  = '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONFIRM = 2'd1,
    S_ACTIVE  = 2'd2,
    S_HOLD    = 2'd3
  } state_e;

  // FSM state and datapath registers
  state_e            state_q, state_d;
  logic [3:0]        run_q, run_d;
  logic [BIN_W-1:0]  ref_q, ref_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Output registers
  logic              active_q, active_d;
  logic              start_q, start_d;
  logic              end_q, end_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Frame classification
  logic [BIN_W:0]    bin_ext_s;
  logic [BIN_W:0]    ref_ext_s;
  logic [BIN_W:0]    diff_s;
  logic              hit_s;
  logic              match_s;
  logic              qualify_s;
  logic              tracking_s;

  // Frame classification: a hit, and a hit close enough to the reference bin.
  // The distance is taken on one extra bit so it never wraps around.
  always_comb begin
    bin_ext_s = {1'b0, frame_bin};
    ref_ext_s = {1'b0, ref_q};
    if (bin_ext_s >= ref_ext_s) begin
      diff_s = bin_ext_s - ref_ext_s;
    end else begin
      diff_s = ref_ext_s - bin_ext_s;
    end
    hit_s   = frame_valid & frame_hit;
    match_s = hit_s & (diff_s <= TOL);
  end

  // State register plus the run / reference / hold datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      run_q   <= 4'd0;
      ref_q   <= BIN_ZERO;
      hold_q  <= HOLD_ZERO;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      ref_q   <= ref_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic; qualify_s flags the frame that declares a new whistle
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    ref_d     = ref_q;
    hold_d    = hold_q;
    qualify_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit_s) begin
          ref_d = frame_bin;
          if (CONFIRM_N == 4'd1) begin
            state_d   = S_ACTIVE;
            run_d     = 4'd0;
            qualify_s = 1'b1;
          end else begin
            state_d = S_CONFIRM;
            run_d   = 4'd1;
          end
        end else begin
          run_d = 4'd0;
        end
      end
      S_CONFIRM: begin
        if (match_s) begin
          ref_d = frame_bin;
          if ((run_q + 4'd1) >= CONFIRM_N) begin
            state_d   = S_ACTIVE;
            run_d     = 4'd0;
            qualify_s = 1'b1;
          end else begin
            run_d = run_q + 4'd1;
          end
        end else if (hit_s) begin
          // A jump in pitch restarts the run from this new bin.
          run_d = 4'd1;
          ref_d = frame_bin;
        end else if (frame_valid) begin
          state_d = S_IDLE;
          run_d   = 4'd0;
        end else begin
          state_d = S_CONFIRM;
        end
      end
      S_ACTIVE: begin
        if (match_s) begin
          // Follow slow pitch drift of the whistle.
          ref_d = frame_bin;
        end else if (frame_valid) begin
          state_d = S_HOLD;
          hold_d  = HOLD_LOAD;
        end else begin
          state_d = S_ACTIVE;
        end
      end
      S_HOLD: begin
        // A returning tone takes priority over the hold timer expiring.
        if (match_s) begin
          state_d = S_ACTIVE;
          ref_d   = frame_bin;
          hold_d  = HOLD_ZERO;
        end else if (hold_q <= HOLD_ONE) begin
          state_d = S_IDLE;
          run_d   = 4'd0;
          hold_d  = HOLD_ZERO;
        end else begin
          hold_d = hold_q - HOLD_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        run_d   = 4'd0;
        ref_d   = BIN_ZERO;
        hold_d  = HOLD_ZERO;
      end
    endcase
  end

  // Output next values, derived from the transition being taken
  always_comb begin
    tracking_s = (state_q == S_ACTIVE) || (state_q == S_HOLD);
    active_d   = (state_d == S_ACTIVE) || (state_d == S_HOLD);
    start_d    = qualify_s;
    end_d      = (state_q == S_HOLD) && (state_d == S_IDLE);

    if (qualify_s || (tracking_s && match_s)) begin
      bin_d = frame_bin;
    end else begin
      bin_d = bin_q;
    end

    // A clear coinciding with a qualify leaves exactly that one event counted.
    if (clear_count) begin
      if (qualify_s) begin
        cnt_d = CNT_ONE;
      end else begin
        cnt_d = CNT_ZERO;
      end
    end else if (qualify_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output registers; reset drops everything without an end pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      bin_q    <= BIN_ZERO;
      cnt_q    <= CNT_ZERO;
    end else begin
      active_q <= active_d;
      start_q  <= start_d;
      end_q    <= end_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
    end
  end

  assign whistle_active = active_q;
  assign whistle_start  = start_q;
  assign whistle_end    = end_q;
  assign whistle_bin    = bin_q;
  assign event_count    = cnt_q;

endmodule

// File: tb/tb_whistle_qualifier.sv
// -----------------------------------------------------------------------------
// tb_whistle_qualifier
//
// Drives whistle_qualifier with directed frame sequences followed by random
// frame traffic, and compares every output after every clock against a
// reference model that tracks the whistle as "run length so far", "whistle
// on/off" and "hold cycles remaining".
// -----------------------------------------------------------------------------
module tb_whistle_qualifier;

  localparam int BIN_W   = 8;
  localparam int CONFIRM = 3;
  localparam int BIN_TOL = 2;
  localparam int HOLD    = 10;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             frame_valid;
  logic             frame_hit;
  logic [BIN_W-1:0] frame_bin;
  logic             clear_count;
  logic             whistle_active;
  logic             whistle_start;
  logic             whistle_end;
  logic [BIN_W-1:0] whistle_bin;
  logic [CNT_W-1:0] event_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_run, m_ref, m_hold, m_bin, m_cnt;
  bit m_on, m_start, m_end;

  whistle_qualifier #(
    .BIN_W(BIN_W), .CONFIRM(CONFIRM), .BIN_TOL(BIN_TOL),
    .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .frame_valid(frame_valid), .frame_hit(frame_hit), .frame_bin(frame_bin),
    .clear_count(clear_count),
    .whistle_active(whistle_active), .whistle_start(whistle_start),
    .whistle_end(whistle_end), .whistle_bin(whistle_bin),
    .event_count(event_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_run = 0; m_ref = 0; m_hold = 0; m_bin = 0; m_cnt = 0;
    m_on = 1'b0; m_start = 1'b0; m_end = 1'b0;
  endfunction

  // One clock of behaviour: what the outputs should show after this edge.
  function automatic void m_step(input bit v, input bit h, input int b, input bit c);
    int  d;
    bit  match;
    m_start = 1'b0;
    m_end   = 1'b0;
    d = b - m_ref;
    if (d < 0) d = -d;
    match = v && h && (d <= BIN_TOL);
    if (!m_on) begin
      if (v && h) begin
        if (m_run > 0 && match) m_run++;
        else m_run = 1;
        m_ref = b;
        if (m_run >= CONFIRM) begin
          m_on = 1'b1; m_hold = 0; m_start = 1'b1; m_bin = b; m_run = 0;
          if (m_cnt < CNT_MAX) m_cnt++;
        end
      end else if (v) begin
        m_run = 0;
      end
    end else begin
      if (match) begin
        m_hold = 0; m_ref = b; m_bin = b;
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) begin
          m_on = 1'b0; m_end = 1'b1; m_run = 0;
        end
      end else if (v) begin
        m_hold = HOLD;
      end
    end
    if (c) m_cnt = m_start ? 1 : 0;
  endfunction

  task automatic check_all();
    check_val("active", 32'(whistle_active), 32'(m_on));
    check_val("start",  32'(whistle_start),  32'(m_start));
    check_val("end",    32'(whistle_end),    32'(m_end));
    check_val("bin",    32'(whistle_bin),    32'(m_bin));
    check_val("count",  32'(event_count),    32'(m_cnt));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_active"}, 32'(whistle_active), 32'd0);
    check_val({tag, "_start"},  32'(whistle_start),  32'd0);
    check_val({tag, "_end"},    32'(whistle_end),    32'd0);
    check_val({tag, "_bin"},    32'(whistle_bin),    32'd0);
    check_val({tag, "_count"},  32'(event_count),    32'd0);
  endtask

  // Starts and ends on a falling edge; outputs sampled 1 time unit after rise.
  task automatic tick(input bit v, input bit h, input int b, input bit c);
    frame_valid = v; frame_hit = h; frame_bin = 8'(b); clear_count = c;
    @(posedge clk);
    m_step(v, h, b, c);
    #1;
    check_all();
    @(negedge clk);
  endtask

  // Quiet cycles; hit/bin wiggle randomly to show they are ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'b0);
    end
  endtask

  task automatic qualify(input int base, input bit clr);
    tick(1'b1, 1'b1, base, 1'b0);
    tick(1'b1, 1'b1, base + 1, 1'b0);
    tick(1'b1, 1'b1, base + 2, clr);
  endtask

  task automatic end_whistle();
    tick(1'b1, 1'b0, 0, 1'b0);
    idle(HOLD);
  endtask

  // Asynchronous reset pulse starting on a falling edge, held over one rise.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    m_reset();
    check_zero(tag);
    @(posedge clk);
    #1;
    check_zero(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int base, pv, b;
    reset_n = 1'b0;
    frame_valid = 1'b0; frame_hit = 1'b0; frame_bin = '0; clear_count = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Three close hits qualify on the cycle after the third.
    tick(1'b1, 1'b1, 20, 1'b0);
    idle(2);
    tick(1'b1, 1'b1, 21, 1'b0);
    check_val("r35_no_start", 32'(whistle_start), 32'd0);
    tick(1'b1, 1'b1, 22, 1'b0);
    check_val("r35_start",  32'(whistle_start),  32'd1);
    check_val("r35_bin",    32'(whistle_bin),    32'd22);
    check_val("r35_count",  32'(event_count),    32'd1);
    check_val("r35_active", 32'(whistle_active), 32'd1);
    idle(1);
    check_val("r35_pulse", 32'(whistle_start), 32'd0);

    // Miss: active held for HOLD cycles, then an end pulse.
    tick(1'b1, 1'b0, 0, 1'b0);
    idle(HOLD - 1);
    check_val("r37_hold_active", 32'(whistle_active), 32'd1);
    check_val("r37_hold_end",    32'(whistle_end),    32'd0);
    idle(1);
    check_val("r37_end",      32'(whistle_end),    32'd1);
    check_val("r37_inactive", 32'(whistle_active), 32'd0);
    idle(1);
    check_val("r37_end_pulse", 32'(whistle_end), 32'd0);

    // Pitch jump restarts the run.
    tick(1'b1, 1'b1, 20, 1'b0);
    tick(1'b1, 1'b1, 21, 1'b0);
    tick(1'b1, 1'b1, 30, 1'b0);
    tick(1'b1, 1'b1, 31, 1'b0);
    check_val("r36_no_start", 32'(whistle_start), 32'd0);
    tick(1'b1, 1'b1, 32, 1'b0);
    check_val("r36_start", 32'(whistle_start), 32'd1);
    check_val("r36_bin",   32'(whistle_bin),   32'd32);
    check_val("r36_count", 32'(event_count),   32'd2);

    // Tone returns during hold: back to active, no new start.
    tick(1'b1, 1'b0, 0, 1'b0);
    idle(4);
    tick(1'b1, 1'b1, 33, 1'b0);
    check_val("r37_ret_active", 32'(whistle_active), 32'd1);
    check_val("r37_ret_start",  32'(whistle_start),  32'd0);
    check_val("r37_ret_count",  32'(event_count),    32'd2);
    check_val("r37_ret_bin",    32'(whistle_bin),    32'd33);
    idle(HOLD + 5);
    check_val("r37_stays", 32'(whistle_active), 32'd1);
    end_whistle();
    check_val("r37_off", 32'(whistle_active), 32'd0);

    // Hit exactly when the hold timer would expire: match wins.
    qualify(50, 1'b0);
    tick(1'b1, 1'b0, 0, 1'b0);
    idle(HOLD - 1);
    tick(1'b1, 1'b1, 53, 1'b0);
    check_val("r38_active", 32'(whistle_active), 32'd1);
    check_val("r38_no_end", 32'(whistle_end),    32'd0);
    idle(3);
    check_val("r38_still", 32'(whistle_active), 32'd1);
    end_whistle();

    // Saturation after 16 whistles, then clear in a qualify cycle.
    for (int i = 0; i < 13; i++) begin
      qualify(60 + i, 1'b0);
      end_whistle();
    end
    check_val("r39_sat", 32'(event_count), 32'd15);
    qualify(70, 1'b1);
    check_val("r39_clr_q", 32'(event_count), 32'd1);
    end_whistle();
    tick(1'b0, 1'b0, 0, 1'b1);
    check_val("r39_clr", 32'(event_count), 32'd0);

    // Reset during hold: outputs drop at once, no end pulse, normal restart.
    qualify(80, 1'b0);
    tick(1'b1, 1'b0, 0, 1'b0);
    idle(3);
    do_reset("r40");
    idle(2);
    qualify(90, 1'b0);
    check_val("r40_start", 32'(whistle_start), 32'd1);
    check_val("r40_count", 32'(event_count),   32'd1);
    check_val("r40_bin",   32'(whistle_bin),   32'd92);

    // Random traffic: bursts of frames around a slowly moving pitch.
    base = 100;
    pv = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) begin
        pv = int'($urandom_range(0, 4));
        if ($urandom_range(0, 2) == 0) base = int'($urandom_range(10, 240));
      end
      b = base + int'($urandom_range(0, 8)) - 4;
      if ($urandom_range(0, 1999) == 0) begin
        do_reset("rnd_rst");
      end else begin
        tick(1'($urandom_range(0, pv * 3) == 0),
             1'($urandom_range(0, 9) < 8),
             b,
             1'($urandom_range(0, 299) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/whistle_qualifier.md
WHISTLE_QUALIFIER -- requirements
Module: whistle_qualifier

Interface
REQ-001 SHALL provide parameter BIN_W, default 8: width of FFT peak-bin index.
REQ-002 SHALL provide parameter CONFIRM, default 3, range 1..15: consecutive matching hit frames needed to declare a whistle.
REQ-003 SHALL provide parameter BIN_TOL, default 2: max |bin difference| counted as the same tone.
REQ-004 SHALL provide parameter HOLD_CYCLES, default 12_500_000, must be >=1: clock cycles output stays asserted after the tone is lost.
REQ-005 SHALL provide parameter CNT_W, default 8: event counter width.
REQ-006 SHALL have one clock and an asynchronous active-low reset; no other clock domains.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 reset_n  input  1  asynchronous active-low reset.
REQ-009 frame_valid  input  1  one-cycle strobe per completed FFT frame.
REQ-010 frame_hit  input  1  whistle detector fired for this frame; sampled only with frame_valid.
REQ-011 frame_bin  input  BIN_W  peak bin of this frame; sampled only with frame_valid.
REQ-012 clear_count  input  1  synchronous clear of event_count.
REQ-013 whistle_active  output  1  qualified and stretched whistle indication.
REQ-014 whistle_start  output  1  one-cycle pulse when a new whistle qualifies.
REQ-015 whistle_end  output  1  one-cycle pulse when whistle_active deasserts.
REQ-016 whistle_bin  output  BIN_W  bin of the current/last qualified whistle.
REQ-017 event_count  output  CNT_W  saturating count of qualified whistles.

Function
REQ-018 SHALL implement states IDLE, CONFIRM, ACTIVE, HOLD; all outputs registered.
REQ-019 "Match" SHALL mean frame_valid & frame_hit & |frame_bin - ref_bin| <= BIN_TOL, difference computed unsigned on BIN_W+1 bits, no wrap.
REQ-020 IDLE: frame_valid&frame_hit -> CONFIRM, run=1, ref_bin=frame_bin; if CONFIRM==1, go directly to ACTIVE (qualify).
REQ-021 CONFIRM: match -> run+1, ref_bin=frame_bin; when run reaches CONFIRM -> ACTIVE (qualify).
REQ-022 CONFIRM: hit out of tolerance -> stay, run=1, ref_bin=frame_bin; frame_valid without hit -> IDLE, run=0.
REQ-023 Qualify SHALL, in the cycle after the qualifying frame_valid: whistle_start=1, whistle_active=1, whistle_bin=qualifying frame_bin, event_count+1.
REQ-024 ACTIVE: match -> stay, ref_bin and whistle_bin updated (tracks drift); frame_valid non-match -> HOLD, hold counter loaded with HOLD_CYCLES.
REQ-025 HOLD: whistle_active stays 1; counter decrements once per cycle; match -> ACTIVE with no whistle_start and no count change.
REQ-026 HOLD: counter reaching 0 -> IDLE; whistle_active=0 and whistle_end=1 the same cycle.
REQ-027 Simultaneous match and counter expiry in HOLD: match SHALL win (ACTIVE, no whistle_end).
REQ-028 event_count SHALL saturate at 2^CNT_W-1.
REQ-029 clear_count with no qualify -> 0; clear_count in the qualify cycle -> 1.
REQ-030 frame_hit/frame_bin SHALL be ignored while frame_valid=0.
REQ-031 Hold counter width SHALL be $clog2(HOLD_CYCLES+1).

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE, run=0, ref_bin=0, hold counter=0, whistle_active=0, whistle_start=0, whistle_end=0, whistle_bin=0, event_count=0.
REQ-033 Reset mid-ACTIVE/HOLD SHALL drop whistle_active without a whistle_end pulse.
REQ-034 First frame_valid after reset release SHALL be processed normally.

Verification (CONFIRM=3, BIN_TOL=2, HOLD_CYCLES=10, CNT_W=4)
REQ-035 Hits bins 20,21,22 on three frame_valid -> whistle_start one cycle after third, whistle_bin=22, event_count=1, whistle_active=1.
REQ-036 Hits 20,21,30,31,32 -> no start after 21; start after 32, whistle_bin=32.
REQ-037 Active at bin 22, then miss frame -> active stays 10 cycles, then whistle_end pulse, active=0; same but hit bin 23 at hold cycle 5 -> back to ACTIVE, no start, event_count unchanged.
REQ-038 Hit frame arriving in the cycle the hold counter expires -> whistle_active stays 1, no whistle_end.
REQ-039 16 qualified whistles -> event_count=15 (saturated); clear_count in a qualify cycle -> event_count=1.
REQ-040 reset_n low for 1 cycle during HOLD -> all outputs 0 asynchronously, no whistle_end, next three matching hits qualify normally.
